// File: rtl/display_controller_pkg.sv
// Shared codes, request modes and FSM states for the display controller.
package display_pkg;

  // Digit codes understood by the segment decoder besides 0-9
  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_E     = 4'hB;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Request modes
  localparam logic [1:0] MODE_OPER  = 2'b00;
  localparam logic [1:0] MODE_RES   = 2'b01;
  localparam logic [1:0] MODE_ERR   = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  // Operand width (0..99 fits in 7 bits)
  localparam int OPER_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    CONV_A,
    CONV_B,
    CONV_R,
    FORMAT,
    COMMIT
  } state_t;

endpackage

// File: rtl/display_controller_bin2bcd_seq.sv
// Serial double-dabble converter. The load edge already performs the first
// shift (nothing to correct while the BCD field is zero), so an nbits-wide
// value is converted in exactly nbits edges; done is high once idle.
module bin2bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  input  logic [4:0]       nbits,
  output logic             done,
  output logic [15:0]      bcd_out
);

  logic [15:0]      bcd_p0;
  logic [WIDTH-1:0] bin_p0;
  logic [4:0]       cnt;

  // Add 3 to every BCD digit that is 5 or more before the next doubling
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Remaining-shift counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= nbits - 5'd1;
    end else if (cnt != 5'd0) begin
      cnt <= cnt - 5'd1;
    end
  end

  // Shift register: load with first shift, then correct-and-shift per edge
  always_ff @(posedge clk) begin
    if (start) begin
      bcd_p0 <= {15'd0, bin_in[WIDTH-1]};
      bin_p0 <= {bin_in[WIDTH-2:0], 1'b0};
    end else if (cnt != 5'd0) begin
      {bcd_p0, bin_p0} <= {add3(bcd_p0), bin_p0} << 1;
    end
  end

  assign done    = (cnt == 5'd0);
  assign bcd_out = bcd_p0;

endmodule

// File: rtl/display_controller.sv
// Display sequencer: accepts display requests, converts them to BCD,
// formats blanking/sign/error patterns and drives four digit codes with blink.
module display_controller
  import display_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int RES_W     = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [6:0]       req_a,
  input  logic [6:0]       req_b,
  input  logic [RES_W-1:0] req_res,
  input  logic             req_neg,
  input  logic             blink_en,
  output logic [3:0]       dig3,
  output logic [3:0]       dig2,
  output logic [3:0]       dig1,
  output logic [3:0]       dig0,
  output logic             disp_valid,
  output logic             busy
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RES_W-OPER_W-1:0] PAD = '0;

  state_t           state_q, state_d;
  logic             xfer;
  logic             req_err;
  logic             conv_start, conv_done;
  logic [RES_W-1:0] conv_bin;
  logic [4:0]       conv_nbits;
  logic [15:0]      conv_bcd;

  logic [1:0]       mode_p0;
  logic [6:0]       b_p0;
  logic             neg_p0;
  logic             err_p0;
  logic [7:0]       a_bcd_p1;
  logic [15:0]      commit_val;
  logic [15:0]      content;
  logic             shown_valid;
  logic [BW-1:0]    blink_cnt;
  logic             phase;
  logic             blank_now;

  // Two-digit operand: tens blanked when zero
  function automatic logic [7:0] fmt_oper(input logic [7:0] bcd);
    return {(bcd[7:4] == 4'd0) ? CODE_BLANK : bcd[7:4], bcd[3:0]};
  endfunction

  // Result: blank leading zeros (dig0 always shown), minus left of the MSD
  function automatic logic [15:0] fmt_result(input logic [15:0] bcd, input logic neg);
    logic [15:0] r;
    logic        lead;
    r    = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && bcd[4*i +: 4] == 4'd0) r[4*i +: 4] = CODE_BLANK;
      else lead = 1'b0;
    end
    if (neg && bcd != 16'd0) begin
      for (int i = 3; i >= 1; i--) begin
        if (r[4*i +: 4] == CODE_BLANK && r[4*(i-1) +: 4] != CODE_BLANK)
          r[4*i +: 4] = CODE_MINUS;
      end
    end
    return r;
  endfunction

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign xfer      = req_valid && req_ready;

  // Range checks on the live request, latched at transfer
  always_comb begin
    req_err = 1'b0;
    unique case (req_mode)
      MODE_OPER: req_err = (req_a > 7'd99) || (req_b > 7'd99);
      MODE_RES:  req_err = (req_res > RES_W'(9999)) || (req_neg && (req_res > RES_W'(999)));
      MODE_ERR:  req_err = 1'b1;
      default:   req_err = 1'b0;
    endcase
  end

  // Next state and converter control; the converter is reused for A then B
  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    conv_bin   = {req_a, PAD};
    conv_nbits = 5'(OPER_W);
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          unique case (req_mode)
            MODE_OPER: begin
              state_d    = CONV_A;
              conv_start = 1'b1;
            end
            MODE_RES: begin
              state_d    = CONV_R;
              conv_start = 1'b1;
              conv_bin   = req_res;
              conv_nbits = 5'(RES_W);
            end
            default: state_d = COMMIT;
          endcase
        end
      end
      CONV_A: begin
        if (conv_done) begin
          state_d    = CONV_B;
          conv_start = 1'b1;
          conv_bin   = {b_p0, PAD};
        end
      end
      CONV_B, CONV_R: begin
        if (conv_done) state_d = FORMAT;
      end
      FORMAT, COMMIT: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Pattern to load on the commit edge
  always_comb begin
    commit_val = {4{CODE_BLANK}};
    if (err_p0) begin
      commit_val = {CODE_E, CODE_BLANK, CODE_BLANK, CODE_BLANK};
    end else if (state_q == FORMAT) begin
      if (mode_p0 == MODE_OPER) commit_val = {fmt_oper(a_bcd_p1), fmt_oper(conv_bcd[7:0])};
      else                      commit_val = fmt_result(conv_bcd, neg_p0);
    end
  end

  bin2bcd_seq #(.WIDTH(RES_W)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (conv_bin),
    .nbits   (conv_nbits),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  // p0: request capture at transfer; p1: operand A BCD held while B converts
  always_ff @(posedge clk) begin
    if (xfer) begin
      mode_p0 <= req_mode;
      b_p0    <= req_b;
      neg_p0  <= req_neg;
      err_p0  <= req_err;
    end
    if (state_q == CONV_A && conv_done) a_bcd_p1 <= conv_bcd[7:0];
  end

  // FSM state, displayed content and valid flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      content     <= {4{CODE_BLANK}};
      shown_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FORMAT || state_q == COMMIT) begin
        content     <= commit_val;
        shown_valid <= 1'b1;
      end
    end
  end

  // Free-running blink divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_now  = blink_en && phase;
  assign dig3       = blank_now ? CODE_BLANK : content[15:12];
  assign dig2       = blank_now ? CODE_BLANK : content[11:8];
  assign dig1       = blank_now ? CODE_BLANK : content[7:4];
  assign dig0       = blank_now ? CODE_BLANK : content[3:0];
  assign disp_valid = shown_valid;

endmodule

// File: tb/tb_display_controller.sv
// Randomized scoreboard bench for display_controller.
module tb_display_controller;

  localparam int BDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [6:0]  req_a, req_b;
  logic [13:0] req_res;
  logic        req_neg;
  logic        blink_en;
  logic [3:0]  dig3, dig2, dig1, dig0;
  logic        disp_valid, busy;
  logic [15:0] dig;

  typedef struct {
    logic [15:0] dg;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   edges  = 0;

  assign dig = {dig3, dig2, dig1, dig0};

  display_controller #(.BLINK_DIV(BDIV), .RES_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_res    (req_res),
    .req_neg    (req_neg),
    .blink_en   (blink_en),
    .dig3       (dig3),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: what the four digits should read for a request
  function automatic logic [15:0] model(input int m, input int a, input int b,
                                        input int r, input bit neg);
    logic [3:0] d[4];
    int n;
    for (int i = 0; i < 4; i++) d[i] = 4'hF;
    if (m == 2 || (m == 0 && (a > 99 || b > 99)) ||
        (m == 1 && (r > 9999 || (neg && r > 999)))) begin
      d[3] = 4'hB;
    end else if (m == 0) begin
      d[3] = (a >= 10) ? 4'(a / 10) : 4'hF;
      d[2] = 4'(a % 10);
      d[1] = (b >= 10) ? 4'(b / 10) : 4'hF;
      d[0] = 4'(b % 10);
    end else if (m == 1) begin
      n = (r >= 1000) ? 4 : (r >= 100) ? 3 : (r >= 10) ? 2 : 1;
      for (int i = 0; i < n; i++) d[i] = 4'((r / (10 ** i)) % 10);
      if (neg && r != 0) d[n] = 4'hA;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  // Edges since reset release, for the blink phase
  always @(posedge clk or negedge reset) begin
    if (!reset) edges = 0;
    else        edges = edges + 1;
  end

  // Monitor: a busy->idle transition is a commit; compare against the queue
  int          run       = 0;
  bit          ready_bad = 0;
  bit          hold_bad  = 0;
  logic [15:0] shown     = 16'hFFFF;
  always @(negedge clk) begin
    if (!reset) begin
      run = 0; ready_bad = 0; hold_bad = 0; shown = 16'hFFFF;
    end else if (busy) begin
      run++;
      if (req_ready) ready_bad = 1;
      if (!blink_en && dig !== shown) hold_bad = 1;
    end else if (run > 0) begin
      check("sb_pending", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("digits", 32'(dig), 32'(e.dg));
        check("latency", 32'(run), 32'(e.lat));
        check("disp_valid", 32'(disp_valid), 32'd1);
        check("ready_low_while_busy", 32'(ready_bad), 32'd0);
        check("hold_until_commit", 32'(hold_bad), 32'd0);
        shown = e.dg;
      end
      run = 0; ready_bad = 0; hold_bad = 0;
    end
  end

  task automatic send(input int m, input int a, input int b, input int r, input bit neg);
    int   guard;
    exp_t e;
    @(negedge clk);
    req_mode  = 2'(m);
    req_a     = 7'(a);
    req_b     = 7'(b);
    req_res   = 14'(r);
    req_neg   = neg;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("req_accepted", 32'(req_ready), 32'd1);
    e.dg  = model(m, a & 127, b & 127, r & 16383, neg);
    e.lat = (m < 2) ? 15 : 1;
    if (req_ready) sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_mode  = 2'($urandom);
    req_a     = 7'($urandom);
    req_b     = 7'($urandom);
    req_res   = 14'($urandom);
    req_neg   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  function automatic int pick_oper();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(95, 127)) : int'($urandom_range(0, 99));
  endfunction

  function automatic int pick_res();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 12));
      1:       return int'($urandom_range(990, 1010));
      2:       return int'($urandom_range(9990, 10010));
      3:       return int'($urandom_range(0, 999));
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_mode = 2'd0; req_a = '0; req_b = '0;
    req_res = '0; req_neg = 1'b0; blink_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_dig", 32'(dig), 32'hFFFF);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // Directed cases
    send(1, 0, 0, 1234, 0);
    send(1, 0, 0, 7, 1);
    send(1, 0, 0, 0, 1);
    send(0, 5, 42, 0, 0);
    send(0, 100, 42, 0, 0);
    send(1, 0, 0, 10000, 0);
    send(1, 0, 0, 1000, 1);
    send(3, 0, 0, 0, 0);
    send(2, 0, 0, 0, 0);
    send(1, 0, 0, 999, 1);
    send(0, 99, 9, 0, 0);
    send(1, 0, 0, 9999, 0);
    wait_idle();

    // Blink over "1234"
    send(1, 0, 0, 1234, 0);
    wait_idle();
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("blink", 32'(dig), (((edges / BDIV) % 2) == 1) ? 32'hFFFF : 32'h1234);
    end
    blink_en = 1'b0;
    #1;
    check("blink_off_restore", 32'(dig), 32'h1234);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 3)), pick_oper(), pick_oper(), pick_res(), 1'($urandom));
    end
    wait_idle();

    // Reset in the middle of a conversion
    send(1, 0, 0, 4321, 0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_dig", 32'(dig), 32'hFFFF);
    check("midrst_disp_valid", 32'(disp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    sbq.delete();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_no_commit", 32'(disp_valid), 32'd0);
    check("post_rst_dig", 32'(dig), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
